// File: rtl/sub_seq_ctrl.sv
// Multi-precision subtractor: streams WORDS x WIDTH-bit words, LS word first, through one narrow subtractor.
// Optional `zero` result flag is enabled by defining SUB_SEQ_ZERO_FLAG_EN.

module param_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};
endmodule

module sub_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH*WORDS-1:0] diff,
`ifdef SUB_SEQ_ZERO_FLAG_EN
    output logic                   zero,
`endif
    output logic                   borrow
);
    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [TOTAL-1:0]  r_a;
    logic [TOTAL-1:0]  r_b;
    logic [IDX_W-1:0]  r_idx;
    logic              r_bin;
    logic [TOTAL-1:0]  r_diff;
    logic              r_borrow;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic              r_or;
`endif

    logic [WIDTH-1:0]  w_aw;
    logic [WIDTH-1:0]  w_bw;
    logic [WIDTH-1:0]  w_sub_b;
    logic [WIDTH-1:0]  w_sub_diff;
    logic              w_sub_borrow;
    logic              w_bypass;
    logic [WIDTH-1:0]  w_dw;
    logic              w_bout;

    // Operands shift right each RUN cycle, so the current word is always the low slice.
    assign w_aw = r_a[WIDTH-1:0];
    assign w_bw = r_b[WIDTH-1:0];

    // Borrow-in is folded into the subtrahend; all-ones plus borrow would wrap, so it bypasses.
    assign w_bypass = r_bin & (&w_bw);
    assign w_sub_b  = w_bw + {{(WIDTH-1){1'b0}}, r_bin};

    param_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a      (w_aw),
        .b      (w_sub_b),
        .diff   (w_sub_diff),
        .borrow (w_sub_borrow)
    );

    assign w_dw   = w_bypass ? w_aw : w_sub_diff;
    assign w_bout = w_bypass ? 1'b1 : w_sub_borrow;

    // NOTE: r_a/r_b are left out of reset on purpose; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
            r_or     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= '0;
                        r_bin   <= 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
                        r_or    <= 1'b0;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff[r_idx*WIDTH +: WIDTH] <= w_dw;
                    r_a   <= r_a >> WIDTH;
                    r_b   <= r_b >> WIDTH;
                    r_bin <= w_bout;
                    r_idx <= r_idx + IDX_W'(1);
`ifdef SUB_SEQ_ZERO_FLAG_EN
                    r_or  <= r_or | (|w_dw);
`endif
                    if (r_idx == LAST_IDX) begin
                        r_borrow <= w_bout;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign diff        = r_diff;
    assign borrow      = r_borrow;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    assign zero        = ~r_or;
`endif

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (WIDTH=8, WORDS=4): directed vectors plus randomized
// operands checked against plain 32-bit arithmetic.

module tb_sub_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] diff;
    logic        borrow;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic        zero;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sub_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .diff        (diff),
`ifdef SUB_SEQ_ZERO_FLAG_EN
        .zero        (zero),
`endif
        .borrow      (borrow)
    );

    // Full handshake for one operation; expected values come from plain unsigned arithmetic.
    task automatic run_op(input string name, input logic [31:0] op_a, input logic [31:0] op_b,
                          input int ready_delay);
        logic [31:0] exp_d;
        logic        exp_b;
        logic [31:0] mask;
        int          cyc;
        exp_d = op_a - op_b;
        exp_b = (op_a < op_b);

        n_total++;
        if (start_ready !== 1'b1) $display("FAIL %s idle_ready: got %b want 1", name, start_ready);
        else n_pass++;

        start_valid = 1'b1;
        a = op_a;
        b = op_b;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom;
        b = $urandom;

        n_total++;
        if (start_ready !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL %s busy_after_accept: got ready=%b valid=%b want 0/0", name, start_ready, res_valid);
        else n_pass++;

        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < WORDS && res_valid !== 1'b1) begin
                mask = (32'd1 << (cyc * WIDTH)) - 32'd1;
                n_total++;
                if ((diff & mask) !== (exp_d & mask))
                    $display("FAIL %s partial_word%0d: got %h want %h", name, cyc, diff & mask, exp_d & mask);
                else n_pass++;
            end
        end

        n_total++;
        if (cyc !== WORDS || res_valid !== 1'b1)
            $display("FAIL %s latency: got %0d cycles (valid=%b) want %0d", name, cyc, res_valid, WORDS);
        else n_pass++;

        n_total++;
        if (diff !== exp_d || borrow !== exp_b)
            $display("FAIL %s result: got diff=%h borrow=%b want diff=%h borrow=%b", name, diff, borrow, exp_d, exp_b);
        else n_pass++;
`ifdef SUB_SEQ_ZERO_FLAG_EN
        n_total++;
        if (zero !== (exp_d == 32'd0))
            $display("FAIL %s zero: got %b want %b", name, zero, (exp_d == 32'd0));
        else n_pass++;
`endif

        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (res_valid !== 1'b1 || diff !== exp_d || borrow !== exp_b)
                $display("FAIL %s hold%0d: got valid=%b diff=%h borrow=%b want 1/%h/%b",
                         name, i, res_valid, diff, borrow, exp_d, exp_b);
            else n_pass++;
        end

        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_total++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL %s transfer: got valid=%b ready=%b want 0/1", name, res_valid, start_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || diff !== 32'd0 || borrow !== 1'b0)
            $display("FAIL reset_state: got ready=%b valid=%b diff=%h borrow=%b want 1/0/00000000/0",
                     start_ready, res_valid, diff, borrow);
        else n_pass++;
`ifdef SUB_SEQ_ZERO_FLAG_EN
        n_total++;
        if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero);
        else n_pass++;
`endif
        @(posedge clk); #1;
        n_total++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL reset_idle: got ready=%b valid=%b want 1/0", start_ready, res_valid);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_op("borrow_chain", 32'h0000_0100, 32'h0000_0001, 0);
        run_op("underflow",    32'h0000_0000, 32'h0000_0001, 1);
        run_op("ones_bypass",  32'h0000_0000, 32'h0000_FF01, 0);
        run_op("max_minus",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_zero_flag();
        run_op("equal",     32'h1234_5678, 32'h1234_5678, 0);
        run_op("off_by_one", 32'h1234_5679, 32'h1234_5678, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        int          cyc;
        exp_d = 32'h8000_0001 - 32'h0000_0003;
        start_valid = 1'b1;
        a = 32'h8000_0001;
        b = 32'h0000_0003;
        @(posedge clk); #1;
        start_valid = 1'b0;
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++;
        if (res_valid !== 1'b1) $display("FAIL bp_timeout: got valid=%b want 1", res_valid);
        else n_pass++;

        for (int i = 0; i < 10; i++) begin
            start_valid = i[0];
            a = $urandom;
            b = $urandom;
            @(posedge clk); #1;
            n_total++;
            if (start_ready !== 1'b0 || res_valid !== 1'b1 || diff !== exp_d || borrow !== 1'b0)
                $display("FAIL bp_hold%0d: got ready=%b valid=%b diff=%h borrow=%b want 0/1/%h/0",
                         i, start_ready, res_valid, diff, borrow, exp_d);
            else n_pass++;
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_total++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL bp_release: got ready=%b valid=%b want 1/0", start_ready, res_valid);
        else n_pass++;
        repeat (WORDS + 1) @(posedge clk);
        #1;
        n_total++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL bp_no_ghost_op: got ready=%b valid=%b want 1/0", start_ready, res_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        start_valid = 1'b1;
        a = 32'h1122_3344;
        b = 32'h0102_0304;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || diff !== 32'd0 || borrow !== 1'b0)
            $display("FAIL abort_state: got valid=%b ready=%b diff=%h borrow=%b want 0/1/00000000/0",
                     res_valid, start_ready, diff, borrow);
        else n_pass++;
`ifdef SUB_SEQ_ZERO_FLAG_EN
        n_total++;
        if (zero !== 1'b1) $display("FAIL abort_zero: got %b want 1", zero);
        else n_pass++;
`endif
        run_op("after_abort", 32'h0000_0010, 32'h0000_0020, 0);
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            for (int w = 0; w < WORDS; w++) begin
                if ($urandom_range(3) == 0) rb[w*WIDTH +: WIDTH] = 8'hFF;
                if ($urandom_range(5) == 0) ra[w*WIDTH +: WIDTH] = rb[w*WIDTH +: WIDTH];
            end
            run_op($sformatf("rand%0d", n), ra, rb, int'($urandom_range(3)));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            run_op($sformatf("b2b%0d", n), $urandom, $urandom, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_flag();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
